perf_monitor_mc: RTL and testbench

//  Next-generation BNN pipeline performance monitor. Tracks up to DEPTH

---
 rtl/perf_monitor_mc.sv | 111 +++++++++++
 tb/tb_perf_monitor_mc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor_mc.sv
// perf_monitor_mc: in-order latency monitor for overlapping inferences.
// Every start pushes a timestamp. Every done pops the oldest one, and the
// block publishes last/min/max/sum/count statistics plus sticky errors.
module perf_monitor_mc #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 32,
  parameter int LAT_W = 16,
  parameter int SUM_W = 32,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_inference,
  input  logic              inference_done,
  input  logic              clear_stats,
  output logic [TS_W-1:0]   total_cycles,
  output logic              lat_valid,
  output logic [LAT_W-1:0]  latency_cycles,
  output logic [LAT_W-1:0]  lat_min,
  output logic [LAT_W-1:0]  lat_max,
  output logic [SUM_W-1:0]  lat_sum,
  output logic [CNT_W-1:0]  done_count,
  output logic [AW:0]       outstanding,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [TS_W-1:0]  cyc_q;
  logic [TS_W-1:0]  ts_mem [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      occ_q, occ_d;
  logic             pop, push;
  logic [TS_W-1:0]  lat_raw;
  logic [LAT_W-1:0] lat_clip;
  logic [SUM_W:0]   sum_ext;

  logic             lat_valid_q, err_ovf_q, err_unf_q;
  logic [LAT_W-1:0] lat_q, min_q, max_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;

  // Pop decision, push-if-room (a same-cycle pop frees a slot), latency math
  always_comb begin
    pop      = inference_done && (occ_q != '0);
    push     = start_inference && ((occ_q != FULL_C) || pop);
    lat_raw  = cyc_q - ts_mem[rd_q];
    lat_clip = ((lat_raw >> LAT_W) != '0) ? '1 : lat_raw[LAT_W-1:0];
    sum_ext  = {1'b0, sum_q} + {{(SUM_W+1-LAT_W){1'b0}}, lat_clip};
    occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Timestamp storage; contents need no reset because occupancy guards reads
  always_ff @(posedge clk) begin
    if (!rst && push) ts_mem[wr_q] <= cyc_q;
  end

  // Free-running counter and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      occ_q <= occ_d;
    end
  end

  // Statistics and sticky errors; clear discards a coincident sample
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      lat_valid_q <= 1'b0;
      lat_q       <= '0;
      min_q       <= '1;
      max_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      lat_valid_q <= pop;
      if (start_inference && !push) err_ovf_q <= 1'b1;
      if (inference_done && !pop)   err_unf_q <= 1'b1;
      if (pop) begin
        lat_q <= lat_clip;
        if (lat_clip < min_q) min_q <= lat_clip;
        if (lat_clip > max_q) max_q <= lat_clip;
        sum_q <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign total_cycles   = cyc_q;
  assign lat_valid      = lat_valid_q;
  assign latency_cycles = lat_q;
  assign lat_min        = min_q;
  assign lat_max        = max_q;
  assign lat_sum        = sum_q;
  assign done_count     = cnt_q;
  assign outstanding    = occ_q;
  assign err_overflow   = err_ovf_q;
  assign err_underflow  = err_unf_q;

endmodule

// File: tb/tb_perf_monitor_mc.sv
// Bench for perf_monitor_mc. A default-width instance and a narrow instance
// (TS_W=6, LAT_W=4, SUM_W=8, CNT_W=4) receive identical strobes. The narrow
// one exercises clamping, counter wrap and saturation within a short run.
module tb_perf_monitor_mc;
  logic clk = 1'b0;
  logic rst, start_inference, inference_done, clear_stats;

  logic [31:0] b_tot;  logic b_vld; logic [15:0] b_lat, b_min, b_max;
  logic [31:0] b_sum;  logic [15:0] b_cnt; logic [2:0] b_out; logic b_ovf, b_unf;
  logic [5:0]  s_tot;  logic s_vld; logic [3:0] s_lat, s_min, s_max;
  logic [7:0]  s_sum;  logic [3:0] s_cnt; logic [2:0] s_out; logic s_ovf, s_unf;

  always #5 clk = ~clk;

  perf_monitor_mc dut_b (
    .clk(clk), .rst(rst), .start_inference(start_inference),
    .inference_done(inference_done), .clear_stats(clear_stats),
    .total_cycles(b_tot), .lat_valid(b_vld), .latency_cycles(b_lat),
    .lat_min(b_min), .lat_max(b_max), .lat_sum(b_sum), .done_count(b_cnt),
    .outstanding(b_out), .err_overflow(b_ovf), .err_underflow(b_unf));

  perf_monitor_mc #(.DEPTH(4), .TS_W(6), .LAT_W(4), .SUM_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start_inference(start_inference),
    .inference_done(inference_done), .clear_stats(clear_stats),
    .total_cycles(s_tot), .lat_valid(s_vld), .latency_cycles(s_lat),
    .lat_min(s_min), .lat_max(s_max), .lat_sum(s_sum), .done_count(s_cnt),
    .outstanding(s_out), .err_overflow(s_ovf), .err_underflow(s_unf));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] mcyc;
  logic [31:0] mq[$];
  longint eq_b[$], eq_s[$];
  bit     m_vld, m_ovf, m_unf;
  longint mb_lat, mb_min, mb_max, mb_sum, mb_cnt;
  longint ms_lat, ms_min, ms_max, ms_sum, ms_cnt;

  task automatic model_clear();
    m_vld = 0; m_ovf = 0; m_unf = 0;
    mb_lat = 0; mb_min = 65535; mb_max = 0; mb_sum = 0; mb_cnt = 0;
    ms_lat = 0; ms_min = 15;    ms_max = 0; ms_sum = 0; ms_cnt = 0;
  endtask

  // One clock: drive strobes, advance the model, then check every output
  task automatic cyc(input bit s, input bit d, input bit c, input bit r);
    bit pop, push;
    logic [31:0] ts, lat;
    longint lb, ls;
    start_inference = s; inference_done = d; clear_stats = c; rst = r;
    pop  = d && (mq.size() > 0);
    push = s && ((mq.size() < 4) || pop);
    lb = 0; ls = 0;
    if (pop) begin
      ts  = mq.pop_front();
      lat = mcyc - ts;
      lb  = (lat > 32'd65535) ? 65535 : longint'(lat);
      ls  = ((lat & 32'd63) > 32'd15) ? 15 : longint'(lat & 32'd63);
    end
    if (push) mq.push_back(mcyc);
    if (r) begin
      model_clear();
      mq.delete();
    end else if (c) begin
      model_clear();
    end else begin
      if (s && !push) m_ovf = 1;
      if (d && !pop)  m_unf = 1;
      m_vld = pop;
      if (pop) begin
        eq_b.push_back(lb);
        eq_s.push_back(ls);
        mb_lat = lb; ms_lat = ls;
        if (lb < mb_min) mb_min = lb;
        if (lb > mb_max) mb_max = lb;
        if (ls < ms_min) ms_min = ls;
        if (ls > ms_max) ms_max = ls;
        mb_sum = (mb_sum + lb > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mb_sum + lb;
        ms_sum = (ms_sum + ls > 255) ? 255 : ms_sum + ls;
        if (mb_cnt < 65535) mb_cnt++;
        if (ms_cnt < 15)    ms_cnt++;
      end
    end
    mcyc = r ? 32'd0 : mcyc + 32'd1;

    @(posedge clk); #1;

    chk("b_valid", b_vld, m_vld);
    chk("s_valid", s_vld, m_vld);
    if (b_vld) begin
      if (eq_b.size() == 0) chk("b_lat_spurious", 1, 0);
      else chk("b_lat", b_lat, eq_b.pop_front());
    end
    if (s_vld) begin
      if (eq_s.size() == 0) chk("s_lat_spurious", 1, 0);
      else chk("s_lat", s_lat, eq_s.pop_front());
    end
    chk("b_total", b_tot, mcyc);
    chk("s_total", s_tot, mcyc & 32'd63);
    chk("b_outstanding", b_out, mq.size());
    chk("s_outstanding", s_out, mq.size());
    chk("b_last", b_lat, mb_lat);   chk("s_last", s_lat, ms_lat);
    chk("b_min", b_min, mb_min);    chk("s_min", s_min, ms_min);
    chk("b_max", b_max, mb_max);    chk("s_max", s_max, ms_max);
    chk("b_sum", b_sum, mb_sum);    chk("s_sum", s_sum, ms_sum);
    chk("b_count", b_cnt, mb_cnt);  chk("s_count", s_cnt, ms_cnt);
    chk("b_ovf", b_ovf, m_ovf);     chk("s_ovf", s_ovf, m_ovf);
    chk("b_unf", b_unf, m_unf);     chk("s_unf", s_unf, m_unf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    mcyc = 0;
    model_clear();
    rst = 1; start_inference = 0; inference_done = 0; clear_stats = 0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_min", b_min, 65535);
    chk("rst_total", b_tot, 0);

    // single inference: start, done seven cycles later
    while (mcyc != 32'd10) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0);
    chk("t1_valid", b_vld, 1); chk("t1_lat", b_lat, 7);
    chk("t1_min", b_min, 7);   chk("t1_max", b_max, 7);
    chk("t1_sum", b_sum, 7);   chk("t1_cnt", b_cnt, 1);
    chk("t1_out", b_out, 0);

    // overlapping inferences
    cyc(0, 0, 1, 0);
    for (int i = 0; i <= 10; i++)
      cyc(i == 0 || i == 2 || i == 4, i == 5 || i == 9 || i == 10, 0, 0);
    chk("t2_min", b_min, 5); chk("t2_max", b_max, 7);
    chk("t2_sum", b_sum, 18); chk("t2_cnt", b_cnt, 3);

    // overflow: five starts into a 4-deep FIFO
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    chk("t3_ovf", b_ovf, 1); chk("t3_out", b_out, 4);
    cyc(0, 1, 0, 0);
    chk("t3_first_lat", b_lat, 5);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);

    // underflow, then start+done on a full FIFO
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    chk("t4_unf", b_unf, 1); chk("t4_novalid", b_vld, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("t4_out", b_out, 4); chk("t4_ovf", b_ovf, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    // start+done on an empty FIFO: underflow and the start is kept
    cyc(1, 1, 0, 0);
    chk("t4_empty_sd_unf", b_unf, 1); chk("t4_empty_sd_out", b_out, 1);
    cyc(0, 1, 0, 0);

    // clamping in the narrow instance, then crossing its 6-bit wrap
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    idle(19);
    cyc(0, 1, 0, 0);
    chk("t5_b_lat", b_lat, 20); chk("t5_s_lat", s_lat, 15);
    chk("t5_s_sum", s_sum, 15);
    while ((mcyc & 32'd63) != 32'd60) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    idle(9);
    cyc(0, 1, 0, 0);
    chk("t5_wrap_s_lat", s_lat, 10); chk("t5_wrap_b_lat", b_lat, 10);

    // clear coinciding with done, then reset with work in flight
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk("t6_min", b_min, 65535); chk("t6_sum", b_sum, 0);
    chk("t6_cnt", b_cnt, 0);     chk("t6_out", b_out, 1);
    chk("t6_novalid", b_vld, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("t6_rst_out", b_out, 0); chk("t6_rst_total", b_tot, 0);
    cyc(0, 1, 0, 0);
    chk("t6_post_rst_unf", b_unf, 1); chk("t6_post_rst_novalid", b_vld, 0);

    // saturation of the narrow sum and count
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 18; k++) begin
      cyc(1, 0, 0, 0);
      idle(19);
      cyc(0, 1, 0, 0);
    end
    chk("sat_s_sum", s_sum, 255); chk("sat_s_cnt", s_cnt, 15);
    chk("sat_s_min", s_min, 15);  chk("sat_b_cnt", b_cnt, 18);
    chk("sat_b_sum", b_sum, 360);
    idle(2);

    chk("b_queue_drained", eq_b.size(), 0);
    chk("s_queue_drained", eq_s.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
